// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (CPU = port 0, loader = port 1) in front of a single unified memory.
// Define ARB_RR_EN for round-robin tie-break; otherwise the CPU wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  // Handshake: a port raises req with stable we/addr/wdata and keeps them until ack;
  // ack is a single-cycle pulse, and a req still high after ack starts a new transaction.
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic              mem_WrEn,
  output logic              mem_RdEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_WrData,
  input  logic [DATA_W-1:0] mem_MemData,
  output logic              grant,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              cap_we_q, cap_we_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
  logic              grant_q, grant_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              win;

  // Winner of the current IDLE cycle; only meaningful when some req is high.
  always_comb begin
`ifdef ARB_RR_EN
    win = (cpu_req & ld_req) ? ~grant_q : ld_req;
`else
    win = ~cpu_req & ld_req;
`endif
  end

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    grant_d     = grant_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req | ld_req) begin
          grant_d     = win;
          cap_we_d    = win ? ld_we    : cpu_we;
          cap_addr_d  = win ? ld_addr  : cpu_addr;
          cap_wdata_d = win ? ld_wdata : cpu_wdata;
          lat_cnt_d   = LAT_LOAD;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt_q == '0) begin
          if (!cap_we_q) begin
            if (grant_q) ld_rdata_d  = mem_MemData;
            else         cpu_rdata_d = mem_MemData;
          end
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      grant_q     <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      grant_q     <= grant_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Memory side is driven purely from registered state so port inputs never reach it.
  assign mem_RdEn    = (state_q == ACCESS) & ~cap_we_q;
  assign mem_WrEn    = (state_q == ACCESS) & cap_we_q & (lat_cnt_q == '0);
  assign mem_addr    = cap_addr_q;
  assign mem_WrData  = cap_wdata_q;
  assign cpu_ack     = (state_q == RESP) & ~grant_q;
  assign ld_ack      = (state_q == RESP) & grant_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ld_rdata    = ld_rdata_q;
  assign cpu_stall   = cpu_req & ~cpu_ack;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: port drivers push expected responses, a monitor
// checks memory strobes and acks against them; memory contents come from a bench-side array.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int TMO = 200;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic          clk, reset;
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ld_req, ld_we, ld_ack;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic          mem_WrEn, mem_RdEn, grant, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_WrData, mem_MemData;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_WrEn(mem_WrEn), .mem_RdEn(mem_RdEn), .mem_addr(mem_addr),
    .mem_WrData(mem_WrData), .mem_MemData(mem_MemData),
    .grant(grant), .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory device and reference state ----------------
  logic [DW-1:0] dev_mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] last_rd [2];
  always @(posedge clk) if (mem_WrEn) dev_mem[mem_addr[7:0]] <= mem_WrData;
  assign mem_MemData = mem_RdEn ? dev_mem[mem_addr[7:0]] : 32'h0BAD_0BAD;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q0[$];
  logic [EXP_W-1:0] exp_q1[$];
  int ack_port_q[$];
  int ack_cyc_q[$];
  int last_wr_cyc = -1;
  int rd_cnt = 0, wr_cnt = 0;
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic failm(input string nm, input int info);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event with no expectation (info %0d, cycle %0d)", nm, info, cyc);
  endtask

  task automatic check_ack(input int port, input logic [DW-1:0] rdata);
    exp_t h;
    if ((port == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      failm("ack_unexpected", port);
    end else begin
      if (port == 0) h = exp_q0.pop_front();
      else           h = exp_q1.pop_front();
      chk($sformatf("rdata_p%0d", port), rdata, h.rdata);
      chk("rd_cycles", rd_cnt, h.we ? 0 : LAT);
      chk("wr_pulses", wr_cnt, h.we ? 1 : 0);
    end
    rd_cnt = 0;
    wr_cnt = 0;
    ack_port_q.push_back(port);
    ack_cyc_q.push_back(cyc);
  endtask

  initial begin : monitor
    exp_t h;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        chk("cpu_stall", cpu_stall, cpu_req & ~cpu_ack);
        if (mem_RdEn || mem_WrEn) begin
          if ((grant ? exp_q1.size() : exp_q0.size()) == 0) begin
            failm("mem_strobe", {30'd0, mem_WrEn, mem_RdEn});
          end else begin
            h = grant ? exp_q1[0] : exp_q0[0];
            chk("mem_addr", mem_addr, h.addr);
            chk("strobe_kind", {mem_WrEn, mem_RdEn}, h.we ? 2'b10 : 2'b01);
            if (mem_WrEn) chk("mem_WrData", mem_WrData, h.wdata);
          end
          if (mem_RdEn) rd_cnt++;
          if (mem_WrEn) begin
            wr_cnt++;
            last_wr_cyc = cyc;
          end
        end
        if (cpu_ack && ld_ack) failm("double_ack", 2);
        else if (cpu_ack) check_ack(0, cpu_rdata);
        else if (ld_ack)  check_ack(1, ld_rdata);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic txn(input int port, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input bit keep, input bit scramble,
                     output int start_cyc, output int ack_cyc);
    exp_t e;
    bit got;
    got     = 1'b0;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    if (we) begin
      e.rdata = last_rd[port];
      ref_mem[addr[7:0]] = wdata;
    end else begin
      e.rdata = ref_mem[addr[7:0]];
      last_rd[port] = e.rdata;
    end
    if (port == 0) begin
      exp_q0.push_back(e);
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end else begin
      exp_q1.push_back(e);
      ld_we = we; ld_addr = addr; ld_wdata = wdata; ld_req = 1'b1;
    end
    start_cyc = cyc;
    ack_cyc   = -1;
    for (int i = 0; i < TMO && !got; i++) begin
      @(negedge clk);
      if (port == 0 ? cpu_ack : ld_ack) begin
        got     = 1'b1;
        ack_cyc = cyc;
      end else if (scramble && i == 1) begin
        if (port == 0) begin cpu_addr = ~addr; cpu_wdata = ~wdata; end
        else           begin ld_addr  = ~addr; ld_wdata  = ~wdata; end
      end
    end
    if (!got) failm("ack_timeout", port);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (port == 0) cpu_req = 1'b0;
      else           ld_req  = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_ack"}, cpu_ack, 0);
    chk({tag, "_ld_ack"}, ld_ack, 0);
    chk({tag, "_mem_WrEn"}, mem_WrEn, 0);
    chk({tag, "_mem_RdEn"}, mem_RdEn, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_WrData"}, mem_WrData, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_ld_rdata"}, ld_rdata, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int s, a, w, last, pc, pl;
    int exp_order[$];
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
      ref_mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
    end
    dev_mem[16] = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;
    last_rd[0] = '0;
    last_rd[1] = '0;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0; ld_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Simultaneous requests held for three transactions each, starting from grant=0.
    pc = 3; pl = 3; last = 0;
    while (pc > 0 || pl > 0) begin
      if (pc > 0 && pl > 0) begin
`ifdef ARB_RR_EN
        w = 1 - last;
`else
        w = 0;
`endif
      end else begin
        w = (pc > 0) ? 0 : 1;
      end
      exp_order.push_back(w);
      last = w;
      if (w == 0) pc--; else pl--;
    end
    ack_port_q.delete();
    ack_cyc_q.delete();
    fork
      begin
        int s0, a0;
        for (int k = 0; k < 3; k++)
          txn(0, k[0], AW'(32'h40 + k), $urandom, k < 2, 1'b0, s0, a0);
      end
      begin
        int s1, a1;
        for (int k = 0; k < 3; k++)
          txn(1, ~k[0], AW'(32'h90 + k), $urandom, k < 2, 1'b0, s1, a1);
      end
    join
    @(posedge clk);
    #1;
    chk("tie_count", ack_port_q.size(), 6);
    for (int k = 0; k < 6 && k < ack_port_q.size(); k++)
      chk($sformatf("tie_order%0d", k), ack_port_q[k], exp_order[k]);
    for (int k = 1; k < ack_cyc_q.size(); k++)
      chk("tie_spacing", ack_cyc_q[k] - ack_cyc_q[k-1], LAT + 2);

    // CPU read of a preloaded word: latency and held read data.
    txn(0, 1'b0, 32'h10, '0, 1'b0, 1'b0, s, a);
    chk("rd_latency", a - s, LAT + 1);
    chk("cpu_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Loader write: single strobe on the last access cycle, ld_rdata untouched.
    txn(1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, s, a);
    chk("wr_latency", a - s, LAT + 1);
    chk("wr_cycle", last_wr_cyc - s, LAT);

    // Port inputs scrambled during ACCESS must not reach the memory pins.
    txn(0, 1'b1, 32'h50, 32'hA5A5_1234, 1'b0, 1'b1, s, a);
    txn(0, 1'b0, 32'h50, '0, 1'b0, 1'b1, s, a);
    chk("scramble_rdata", cpu_rdata, 32'hA5A5_1234);

    // Back-to-back CPU transactions with req held across ack.
    ack_cyc_q.delete();
    txn(0, 1'b0, 32'h11, '0, 1'b1, 1'b0, s, a);
    txn(0, 1'b1, 32'h12, 32'h0F0F_5555, 1'b1, 1'b0, s, a);
    txn(0, 1'b0, 32'h12, '0, 1'b0, 1'b0, s, a);
    chk("b2b_count", ack_cyc_q.size(), 3);
    for (int k = 1; k < ack_cyc_q.size(); k++)
      chk("b2b_spacing", ack_cyc_q[k] - ack_cyc_q[k-1], LAT + 2);

    // Random concurrent traffic on disjoint address halves.
    fork
      begin
        int s0, a0, g0;
        bit k0;
        for (int k = 0; k < 20; k++) begin
          k0 = (k < 19) && ($urandom_range(0, 2) == 0);
          txn(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 127)), $urandom, k0, 1'b0, s0, a0);
          g0 = k0 ? 0 : $urandom_range(0, 3);
          if (g0 > 0) begin
            repeat (g0) @(posedge clk);
            #1;
          end
        end
      end
      begin
        int s1, a1, g1;
        bit k1;
        for (int k = 0; k < 20; k++) begin
          k1 = (k < 19) && ($urandom_range(0, 2) == 0);
          txn(1, 1'($urandom_range(0, 1)), AW'($urandom_range(128, 255)), $urandom, k1, 1'b0, s1, a1);
          g1 = k1 ? 0 : $urandom_range(0, 3);
          if (g1 > 0) begin
            repeat (g1) @(posedge clk);
            #1;
          end
        end
      end
    join
    txn(0, 1'b0, 32'h10, '0, 1'b0, 1'b0, s, a);
    chk("queues_drained", exp_q0.size() + exp_q1.size(), 0);

    // Reset in the second ACCESS cycle of a loader write.
    ld_we = 1'b1; ld_addr = 32'h30; ld_wdata = 32'hCAFE_F00D; ld_req = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ld_req = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    chk("abort_no_wren", mem_WrEn, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    txn(1, 1'b0, 32'h30, '0, 1'b0, 1'b0, s, a);
    chk("abort_mem_kept", ld_rdata, ref_mem[8'h30]);
    txn(0, 1'b1, 32'h31, 32'h7777_0001, 1'b0, 1'b0, s, a);
    chk("post_reset_wr_rdata", cpu_rdata, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
